// File: rtl/register_bus_master_pkg.sv
// Shared encodings for the register bus master: request opcodes and FSM states.
package register_bus_master_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_MOVE  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD_EN  = 3'd2,
        RD_CAP = 3'd3,
        MV_WR  = 3'd4,
        RSP    = 3'd5
    } state_e;

endpackage

// File: rtl/register_bus_master_bus_addr_decoder.sv
// Index plus enable to one-hot register select; shared by the output-enable and load paths.
module bus_addr_decoder #(
    parameter int AddrBits = 3
) (
    input  logic [AddrBits-1:0]    idx_i,
    input  logic                   en_i,
    output logic [2**AddrBits-1:0] onehot_o
);

    // One-hot decode, all zeros when disabled
    always_comb begin
        onehot_o = {(2**AddrBits){1'b0}};
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end else begin
            onehot_o = {(2**AddrBits){1'b0}};
        end
    end

endmodule

// File: rtl/register_bus_master.sv
// Sequences WRITE / READ / MOVE requests onto a shared tri-state register bus.
// All outputs are registered; they are computed from the next state so bus timing matches the FSM.
module register_bus_master
    import register_bus_master_pkg::*;
#(
    parameter int NrOfBits = 8,
    parameter int AddrBits = 3
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [AddrBits-1:0]    req_src,
    input  logic [AddrBits-1:0]    req_dst,
    input  logic [NrOfBits-1:0]    req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NrOfBits-1:0]    rsp_data,
    output logic                   rsp_err,
    output logic [2**AddrBits-1:0] bus_cs_n,
    output logic [2**AddrBits-1:0] bus_ld,
    output logic                   bus_tick,
    output logic [NrOfBits-1:0]    bus_wdata,
    input  logic [NrOfBits-1:0]    bus_rdata
);

    localparam int NrOfRegs = 2**AddrBits;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [AddrBits-1:0]   src_q, src_d;
    logic [AddrBits-1:0]   dst_q, dst_d;
    logic [NrOfBits-1:0]   data_q, data_d;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [NrOfBits-1:0]   rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [NrOfRegs-1:0]   bus_cs_n_q, bus_ld_q;
    logic                  bus_tick_q;
    logic [NrOfBits-1:0]   bus_wdata_q, bus_wdata_d;
    logic                  cs_en_s, ld_en_s;
    logic [NrOfRegs-1:0]   cs_onehot_s, ld_onehot_s;

    // Next-state logic; data_q doubles as the capture register for READ/MOVE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d   = op_e'(req_op);
                    src_d  = req_src;
                    dst_d  = req_dst;
                    data_d = req_data;
                    case (op_e'(req_op))
                        OP_WRITE:         state_d = WR;
                        OP_READ, OP_MOVE: state_d = RD_EN;
                        default:          state_d = RSP;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            WR:     state_d = RSP;
            RD_EN:  state_d = RD_CAP;
            RD_CAP: begin
                data_d = bus_rdata;
                if (op_q == OP_MOVE) begin
                    state_d = MV_WR;
                end else begin
                    state_d = RSP;
                end
            end
            MV_WR:  state_d = RSP;
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RSP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and response values for the cycle the FSM is about to enter
    always_comb begin
        cs_en_s     = (state_d == RD_EN) || (state_d == RD_CAP);
        ld_en_s     = (state_d == WR) || (state_d == MV_WR);
        bus_wdata_d = {NrOfBits{1'b0}};
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (ld_en_s) begin
            bus_wdata_d = data_d;
        end else begin
            bus_wdata_d = {NrOfBits{1'b0}};
        end
        // Response fields are frozen on RSP entry so they stay stable while stalled
        if ((state_d == RSP) && (state_q != RSP)) begin
            rsp_err_d = (op_d == OP_RSVD);
            if ((op_d == OP_READ) || (op_d == OP_MOVE)) begin
                rsp_data_d = data_d;
            end else begin
                rsp_data_d = {NrOfBits{1'b0}};
            end
        end else begin
            rsp_data_d = rsp_data_q;
            rsp_err_d  = rsp_err_q;
        end
    end

    bus_addr_decoder #(.AddrBits(AddrBits)) u_cs_dec (
        .idx_i    (src_d),
        .en_i     (cs_en_s),
        .onehot_o (cs_onehot_s)
    );

    bus_addr_decoder #(.AddrBits(AddrBits)) u_ld_dec (
        .idx_i    (dst_d),
        .en_i     (ld_en_s),
        .onehot_o (ld_onehot_s)
    );

    // State, latched request fields and registered outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            op_q        <= OP_WRITE;
            src_q       <= {AddrBits{1'b0}};
            dst_q       <= {AddrBits{1'b0}};
            data_q      <= {NrOfBits{1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {NrOfBits{1'b0}};
            rsp_err_q   <= 1'b0;
            bus_cs_n_q  <= {NrOfRegs{1'b1}};
            bus_ld_q    <= {NrOfRegs{1'b0}};
            bus_tick_q  <= 1'b0;
            bus_wdata_q <= {NrOfBits{1'b0}};
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            data_q      <= data_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RSP);
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            bus_cs_n_q  <= ~cs_onehot_s;
            bus_ld_q    <= ld_onehot_s;
            bus_tick_q  <= |ld_onehot_s;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign bus_cs_n  = bus_cs_n_q;
    assign bus_ld    = bus_ld_q;
    assign bus_tick  = bus_tick_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_register_bus_master.sv
// Scoreboard bench for register_bus_master with a behavioural register-file bus model.
module tb_register_bus_master;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [2:0] req_src = 3'd0;
    logic [2:0] req_dst = 3'd0;
    logic [7:0] req_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] bus_cs_n;
    logic [7:0] bus_ld;
    logic       bus_tick;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] regs [8] = '{8'h10, 8'h77, 8'h3C, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    logic [7:0] tr_cs   [0:9];
    logic [7:0] tr_ld   [0:9];
    logic       tr_tick [0:9];
    logic [7:0] tr_wd   [0:9];

    register_bus_master dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .bus_cs_n  (bus_cs_n),
        .bus_ld    (bus_ld),
        .bus_tick  (bus_tick),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    always #5 Clock = ~Clock;

    // Register file model: tri-state read bus and clock-enabled loads
    always_comb begin
        bus_rdata = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (!bus_cs_n[i]) bus_rdata = regs[i];
        end
    end

    always @(posedge Clock) begin
        for (int j = 0; j < 8; j++) begin
            if (bus_ld[j]) regs[j] <= bus_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop expected response on each handshake
    always @(negedge Clock) begin
        exp_t e;
        if (Reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got data %0h err %0b expected no response", rsp_data, rsp_err);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", rsp_err, e.err);
            end
        end
    end

    // Bus invariants every cycle outside reset
    always @(negedge Clock) begin
        if (Reset) begin
            chk("cs_onehot0", $onehot0(~bus_cs_n), 1);
            chk("ld_onehot0", $onehot0(bus_ld), 1);
            chk("cs_ld_excl", (&bus_cs_n) || (bus_ld == 8'h00), 1);
            chk("tick_is_or", bus_tick, |bus_ld);
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                          input logic [7:0] data, input logic [7:0] exp_d, input logic exp_e,
                          input int exp_lat, input bit hold, input string nm);
        int lat;
        lat = 0;
        @(posedge Clock); #1;
        req_valid = 1'b1; req_op = op; req_src = src; req_dst = dst; req_data = data;
        exp_q.push_back('{err: exp_e, data: exp_d});
        @(negedge Clock);
        chk({nm, "_req_ready"}, req_ready, 1);
        @(posedge Clock); #1;
        req_valid = 1'b0; req_data = 8'hEE;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clock);
            tr_cs[c] = bus_cs_n; tr_ld[c] = bus_ld; tr_tick[c] = bus_tick; tr_wd[c] = bus_wdata;
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        chk({nm, "_latency"}, lat, exp_lat);
        if (!hold) begin
            @(negedge Clock);
            chk({nm, "_rsp_drop"}, rsp_valid, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #1 Reset = 1'b0;
        #2;
        chk("rst_cs_n", bus_cs_n, 8'hFF);
        chk("rst_ld", bus_ld, 8'h00);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        @(negedge Clock);
        Reset = 1'b1;

        // WRITE dst=5 A5
        do_req(2'b00, 3'd0, 3'd5, 8'hA5, 8'h00, 1'b0, 2, 1'b0, "wr");
        chk("wr_ld", tr_ld[1], 8'b0010_0000);
        chk("wr_tick", tr_tick[1], 1);
        chk("wr_wdata", tr_wd[1], 8'hA5);
        chk("wr_ld_done", tr_ld[2], 8'h00);

        // READ src=2
        do_req(2'b01, 3'd2, 3'd0, 8'h00, 8'h3C, 1'b0, 3, 1'b0, "rd");
        chk("rd_cs1", tr_cs[1], 8'b1111_1011);
        chk("rd_cs2", tr_cs[2], 8'b1111_1011);
        chk("rd_cs3", tr_cs[3], 8'hFF);

        // MOVE src=1 dst=6
        do_req(2'b10, 3'd1, 3'd6, 8'h00, 8'h77, 1'b0, 4, 1'b0, "mv");
        chk("mv_cs1", tr_cs[1], 8'b1111_1101);
        chk("mv_cs2", tr_cs[2], 8'b1111_1101);
        chk("mv_ld", tr_ld[3], 8'b0100_0000);
        chk("mv_cs3", tr_cs[3], 8'hFF);
        chk("mv_wdata", tr_wd[3], 8'h77);
        chk("mv_reg6", regs[6], 8'h77);

        // Reserved op: error, no bus activity
        do_req(2'b11, 3'd3, 3'd4, 8'hFF, 8'h00, 1'b1, 1, 1'b0, "rsvd");
        chk("rsvd_ld", tr_ld[1], 8'h00);
        chk("rsvd_cs", tr_cs[1], 8'hFF);

        // MOVE with src==dst writes back the same value
        do_req(2'b10, 3'd2, 3'd2, 8'h00, 8'h3C, 1'b0, 4, 1'b0, "mv_self");
        chk("mv_self_ld", tr_ld[3], 8'b0000_0100);
        chk("mv_self_wdata", tr_wd[3], 8'h3C);

        // Read back the earlier WRITE
        do_req(2'b01, 3'd5, 3'd0, 8'h00, 8'hA5, 1'b0, 3, 1'b0, "rd5");

        // Stalled response: stable outputs, new requests ignored
        @(posedge Clock); #1;
        rsp_ready = 1'b0;
        do_req(2'b01, 3'd6, 3'd0, 8'h00, 8'h77, 1'b0, 3, 1'b1, "stall");
        for (int k = 0; k < 5; k++) begin
            @(posedge Clock); #1;
            req_valid = 1'b1; req_op = 2'b00; req_dst = 3'd3; req_data = 8'h5A;
            @(negedge Clock);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 8'h77);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_no_ld", bus_ld, 8'h00);
        end
        @(posedge Clock); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        chk("stall_drop", rsp_valid, 0);
        chk("stall_idle", req_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            chk("stall_ignored_ld", bus_ld, 8'h00);
            chk("stall_ignored_rsp", rsp_valid, 0);
        end
        chk("stall_reg3", regs[3], 8'h13);

        // Reset during RD_CAP aborts the READ
        @(posedge Clock); #1;
        req_valid = 1'b1; req_op = 2'b01; req_src = 3'd2;
        @(posedge Clock); #1;
        req_valid = 1'b0;
        @(posedge Clock); #1;
        chk("rcap_cs", bus_cs_n, 8'b1111_1011);
        Reset = 1'b0;
        #1;
        chk("arst_cs_n", bus_cs_n, 8'hFF);
        chk("arst_ld", bus_ld, 8'h00);
        chk("arst_tick", bus_tick, 0);
        chk("arst_wdata", bus_wdata, 8'h00);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_data", rsp_data, 8'h00);
        chk("arst_rsp_err", rsp_err, 0);
        @(negedge Clock);
        Reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            chk("post_rst_cs", bus_cs_n, 8'hFF);
            chk("post_rst_ld", bus_ld, 8'h00);
            chk("post_rst_rsp", rsp_valid, 0);
        end

        // Normal operation resumes
        do_req(2'b00, 3'd0, 3'd0, 8'h11, 8'h00, 1'b0, 2, 1'b0, "wr0");
        chk("wr0_ld", tr_ld[1], 8'b0000_0001);
        do_req(2'b01, 3'd0, 3'd0, 8'h00, 8'h11, 1'b0, 3, 1'b0, "rd0");

        repeat (3) @(negedge Clock);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
